// File: rtl/countdown_timer.sv
// Memory-mapped 32-bit countdown timer: CTRL (+0x0), PRESET (+0x4), COUNT (+0x8, read-only).
// Optional prescaler is compiled in when TIMER_PRESCALE_EN is defined.
module countdown_timer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CNT = 2'd2, INT = 2'd3} state_t;

  state_t      state, state_nxt;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic wr, ctrl_wr, preset_wr;
  logic en, auto_reload;
  logic tick, cnt_run;
  logic do_load, do_dec, do_set, do_int;

  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("countdown_timer: PRESCALE must be 1..65535");
  end

  assign wr          = sel & (|byteen);
  assign ctrl_wr     = wr & (addr[3:2] == 2'b00);
  assign preset_wr   = wr & (addr[3:2] == 2'b01);
  assign en          = ctrl[0];
  assign auto_reload = (ctrl[2:1] == 2'b01);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = LOAD;
      LOAD:    state_nxt = CNT;
      CNT: begin
        if (!en)              state_nxt = IDLE;
        else if (count == '0) state_nxt = INT;
      end
      INT:     state_nxt = auto_reload ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded datapath controls
  always_comb begin
    do_load = 1'b0;
    cnt_run = 1'b0;
    do_set  = 1'b0;
    do_int  = 1'b0;
    case (state)
      LOAD: do_load = 1'b1;
      CNT: begin
        cnt_run = en && (count != '0);
        do_set  = en && (count == '0);
      end
      INT:  do_int = 1'b1;
      default: ;
    endcase
  end

  assign do_dec = cnt_run & tick;

`ifdef TIMER_PRESCALE_EN
  logic [15:0] psc;
  assign tick = (psc == 16'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (reset)        psc <= '0;
    else if (do_load) psc <= '0;
    else if (cnt_run) psc <= tick ? 16'd0 : psc + 16'd1;
  end
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      // A CPU write to CTRL overrides the one-shot EN clear in the same cycle
      if (ctrl_wr) begin
        if (byteen[0]) ctrl <= wdata[3:0];
      end else if (do_int && !auto_reload) begin
        ctrl[0] <= 1'b0;
      end

      for (int i = 0; i < 4; i++)
        if (preset_wr && byteen[i]) preset[8*i +: 8] <= wdata[8*i +: 8];

      if (do_load)     count <= preset;
      else if (do_dec) count <= count - 32'd1;

      // Flag goes up on the edge entering INT so irq lands at t+3+N
      if (ctrl_wr)                          irq_flag <= 1'b0;
      else if (do_set)                      irq_flag <= 1'b1;
      else if (do_load || (do_int && auto_reload)) irq_flag <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr[3:2])
      2'b00:   rdata = {28'd0, ctrl};
      2'b01:   rdata = preset;
      2'b10:   rdata = count;
      default: rdata = '0;
    endcase
  end

  assign irq = irq_flag & ctrl[3];

  logic unused_addr;
  assign unused_addr = ^{addr[31:4], addr[1:0]};

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: expected samples are queued with the stimulus
// and drained against rdata/irq at falling edges.
module tb_countdown_timer;

`ifdef TIMER_PRESCALE_EN
  localparam int unsigned PSC = 4;
`else
  localparam int unsigned PSC = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  byteen = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    int          adv;  // falling edges to wait before sampling
    int          src;  // 0..3 register slot, 4 = irq
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];

  countdown_timer #(.PRESCALE(PSC)) dut (
    .clk(clk), .reset(reset), .sel(sel), .addr(addr),
    .byteen(byteen), .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: timeout, %0d expectations pending", exp_q.size());
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int adv, input int src, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.adv = adv; e.src = src; e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] got;
    logic [1:0]  slot;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      repeat (e.adv) @(negedge clk);
      if (e.src == 4) begin
        got = {31'd0, irq};
      end else begin
        slot = e.src[1:0];
        addr = {28'd0, slot, 2'b00};
        #1 got = rdata;
      end
      chk(e.tag, got, e.val);
    end
  endtask

  // Drive at a falling edge, write on the next rising edge, return at the following falling edge
  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    sel = 1'b1; addr = a; byteen = be; wdata = d;
    @(posedge clk);
    @(negedge clk);
    sel = 1'b0; byteen = '0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    push("rst_ctrl", 0, 0, 0);
    push("rst_preset", 0, 1, 0);
    push("rst_count", 0, 2, 0);
    push("rst_irq", 0, 4, 0);
    drain();

    // One-shot with irq enabled, PRESET=5
    wr(32'h4, 4'hF, 32'd5);
    wr(32'h0, 4'hF, 32'h9);
    push("s2_cnt5", 2, 2, 5);
    for (int v = 4; v >= 0; v--) push("s2_cnt", 1, 2, v);
    push("s2_irq_pre", 0, 4, 0);
    push("s2_irq_rise", 1, 4, 1);
    push("s2_en_clr", 1, 0, 32'h8);
    push("s2_irq_hold", 5, 4, 1);
    push("s2_cnt_term", 0, 2, 0);
    drain();
    wr(32'h0, 4'hF, 32'h8);
    push("s2_irq_cleared", 0, 4, 0);
    drain();

    // Auto-reload, PRESET=2: one-cycle pulse every 5 cycles
    wr(32'h4, 4'hF, 32'd2);
    wr(32'h0, 4'hF, 32'hB);
    push("s3_irq_t4", 4, 4, 0);
    push("s3_irq_t5", 1, 4, 1);
    push("s3_cnt_t5", 0, 2, 0);
    push("s3_irq_t6", 1, 4, 0);
    push("s3_reload", 1, 2, 2);
    push("s3_irq_t9", 2, 4, 0);
    push("s3_irq_t10", 1, 4, 1);
    push("s3_irq_t11", 1, 4, 0);
    push("s3_irq_t15", 4, 4, 1);
    drain();
    wr(32'h0, 4'hF, 32'h0);
    repeat (4) @(negedge clk);

    // One-shot with IM=0: irq never asserts
    wr(32'h4, 4'hF, 32'd5);
    wr(32'h0, 4'hF, 32'h1);
    for (int c = 0; c < 10; c++) push("s4_irq_masked", 1, 4, 0);
    push("s4_en_clr", 0, 0, 0);
    push("s4_cnt", 0, 2, 0);
    drain();

    // PRESET=0, plus a CTRL write landing on the INT edge
    wr(32'h4, 4'hF, 32'd0);
    wr(32'h0, 4'hF, 32'h9);
    push("p0_irq_t2", 2, 4, 0);
    push("p0_irq_t3", 1, 4, 1);
    drain();
    wr(32'h0, 4'hF, 32'h9);
    push("p0_cpu_wins", 0, 0, 32'h9);
    push("p0_flag_clr", 0, 4, 0);
    push("p0_irq_t6", 2, 4, 0);
    push("p0_irq_t7", 1, 4, 1);
    push("p0_en_clr", 1, 0, 32'h8);
    push("p0_no_wrap", 2, 2, 0);
    drain();
    wr(32'h0, 4'hF, 32'h0);

    // Freeze mid-count, byte-lane restart, PRESET write during CNT
    wr(32'h4, 4'hF, 32'h100);
    wr(32'h0, 4'hF, 32'h1);
    repeat (9) @(negedge clk);
    wr(32'h0, 4'hF, 32'h0);
    push("s5_freeze", 0, 2, 32'hF8);
    push("s5_frozen", 4, 2, 32'hF8);
    drain();
    wr(32'h0, 4'b0001, 32'h1);
    push("s5_restart_t1", 1, 2, 32'hF8);
    push("s5_restart_t2", 1, 2, 32'h100);
    push("s5_restart_t3", 1, 2, 32'hFF);
    drain();
    wr(32'h4, 4'hF, 32'h20);
    push("s5_preset_late", 0, 2, 32'hFE);
    drain();
    wr(32'h8, 4'hF, 32'h1234);
    push("s5_count_ro", 0, 2, 32'hFD);
    drain();
    wr(32'h0, 4'hF, 32'h0);
    wr(32'h4, 4'b0100, 32'h00AB_0000);
    push("s5_preset_byte", 0, 1, 32'h00AB_0020);
    push("s5_slot3", 0, 3, 0);
    drain();
    wr(32'h4, 4'hF, 32'h20);
    wr(32'h0, 4'hF, 32'h1);
    push("s5_new_preset", 2, 2, 32'h20);
    drain();
    wr(32'h0, 4'hF, 32'h0);
    repeat (3) @(negedge clk);

`ifdef TIMER_PRESCALE_EN
    wr(32'h4, 4'hF, 32'd3);
    wr(32'h0, 4'hF, 32'h9);
    push("s6_cnt_t2", 2, 2, 3);
    push("s6_cnt_t5", 3, 2, 3);
    push("s6_cnt_t6", 1, 2, 2);
    push("s6_cnt_t10", 4, 2, 1);
    push("s6_cnt_t14", 4, 2, 0);
    push("s6_irq_t14", 0, 4, 0);
    push("s6_irq_t15", 1, 4, 1);
    drain();
    wr(32'h0, 4'hF, 32'h0);
`endif

    // Reset in the middle of a count
    wr(32'h4, 4'hF, 32'h50);
    wr(32'h0, 4'hF, 32'h9);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    push("mr_ctrl", 0, 0, 0);
    push("mr_preset", 0, 1, 0);
    push("mr_count", 0, 2, 0);
    push("mr_irq", 0, 4, 0);
    push("mr_idle", 3, 2, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
